// File: rtl/mem_stage_ctrl_if.sv
// ============================================================================
// Module   : mem_stage_ctrl_if
// Purpose  : Data-memory request/response bus between MEM stage and memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_stage_ctrl_if;
    logic [15:0] memAddr;
    logic [15:0] memWrData;
    logic        memRd;
    logic        memWr;
    logic [15:0] memRdData;
    logic        memDone;

    modport master (
        output memAddr, memWrData, memRd, memWr,
        input  memRdData, memDone
    );

    modport slave (
        input  memAddr, memWrData, memRd, memWr,
        output memRdData, memDone
    );
endinterface

`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
// ============================================================================
// Module   : mem_stage_ctrl
// Purpose  : MEM-stage controller: multi-cycle load/store handshake, front-end
//            stall, timeout/misalignment faults and registered MEM/WB outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage_ctrl #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 8
) (
    input  wire         clk,
    input  wire         rst,
    input  wire  [15:0] inXOut,
    input  wire  [15:0] inRead2Data,
    input  wire  [15:0] inPlusTwoPC,
    input  wire  [2:0]  inWriteRegister,
    input  wire         inMemoryWrite,
    input  wire         inMemoryRead,
    input  wire         inMemoryToRegister,
    input  wire         inRegisterWrite,
    input  wire         inHalt,
    input  wire         inCreateDump,
    input  wire         inLink,
    mem_stage_ctrl_if.master mem,
    output logic        stall,
    output logic [15:0] outReadData,
    output logic [15:0] outXout,
    output logic [15:0] outPlusTwoPC,
    output logic [2:0]  outWriteRegister,
    output logic        outRegisterWrite,
    output logic        outMemoryToRegister,
    output logic        outLink,
    output logic        outHalt,
    output logic        outCreateDump,
    output logic        outValid,
    output logic        outErr
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic [15:0] read_data;
        logic [15:0] xout;
        logic [15:0] plus_two_pc;
        logic [2:0]  write_register;
        logic        register_write;
        logic        memory_to_register;
        logic        link;
        logic        halt;
        logic        create_dump;
        logic        valid;
        logic        err;
    } mw_t;

    state_t            r_state_q;
    state_t            w_state_d;
    logic [CNT_W-1:0]  r_cnt_q;
    logic [CNT_W-1:0]  w_cnt_d;
    mw_t               r_mw_q;
    mw_t               w_mw_d;

    logic              w_memop;
    logic              w_misaligned;
    logic              w_timeout;
    logic              w_stall;
    logic              w_rd;
    logic              w_wr;
    mw_t               w_pass;
    mw_t               w_fault;

    always_comb begin
        w_memop      = inMemoryRead | inMemoryWrite;
        w_misaligned = w_memop & inXOut[0];
        w_timeout    = (r_state_q == S_WAIT) & ~mem.memDone & (r_cnt_q == C_CNT_LAST);

        w_pass = '{
            read_data:          16'h0000,
            xout:               inXOut,
            plus_two_pc:        inPlusTwoPC,
            write_register:     inWriteRegister,
            register_write:     inRegisterWrite,
            memory_to_register: inMemoryToRegister,
            link:               inLink,
            halt:               inHalt,
            create_dump:        inCreateDump,
            valid:              1'b1,
            err:                1'b0
        };

        // Faulting instructions retire as a halting, non-writing instruction.
        w_fault                = w_pass;
        w_fault.register_write = 1'b0;
        w_fault.halt           = 1'b1;
        w_fault.err            = 1'b1;

        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_mw_d    = '0;
        w_stall   = 1'b0;
        w_rd      = 1'b0;
        w_wr      = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                if (!w_memop) begin
                    w_mw_d = w_pass;
                end else if (w_misaligned) begin
                    w_mw_d = w_fault;
                end else begin
                    // A combined read+write issues only the write.
                    w_rd      = inMemoryRead & ~inMemoryWrite;
                    w_wr      = inMemoryWrite;
                    w_stall   = 1'b1;
                    w_state_d = S_WAIT;
                    w_cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (mem.memDone) begin
                    w_mw_d           = w_pass;
                    w_mw_d.read_data = inMemoryWrite ? 16'h0000 : mem.memRdData;
                    w_state_d        = S_IDLE;
                end else if (w_timeout) begin
                    w_mw_d    = w_fault;
                    w_state_d = S_IDLE;
                    w_cnt_d   = '0;
                end else begin
                    w_stall = 1'b1;
                    w_cnt_d = r_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                w_state_d = S_IDLE;
                w_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_IDLE;
            r_cnt_q   <= '0;
            r_mw_q    <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_mw_q    <= w_mw_d;
        end
    end

    assign mem.memAddr   = inXOut;
    assign mem.memWrData = inRead2Data;
    assign mem.memRd     = w_rd & ~rst;
    assign mem.memWr     = w_wr & ~rst;
    assign stall         = w_stall;

    assign outReadData         = r_mw_q.read_data;
    assign outXout             = r_mw_q.xout;
    assign outPlusTwoPC        = r_mw_q.plus_two_pc;
    assign outWriteRegister    = r_mw_q.write_register;
    assign outRegisterWrite    = r_mw_q.register_write;
    assign outMemoryToRegister = r_mw_q.memory_to_register;
    assign outLink             = r_mw_q.link;
    assign outHalt             = r_mw_q.halt;
    assign outCreateDump       = r_mw_q.create_dump;
    assign outValid            = r_mw_q.valid;
    assign outErr              = r_mw_q.err;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
// ============================================================================
// Module   : tb_mem_stage_ctrl
// Purpose  : Self-checking bench for mem_stage_ctrl with a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_stage_ctrl;

    localparam int T = 15;

    typedef struct packed {
        logic [15:0] rd;
        logic [15:0] x;
        logic [15:0] pc;
        logic [2:0]  wreg;
        logic        rw, m2r, link, halt, dump, valid, err;
    } mw_t;

    typedef struct packed {
        logic        stall, stall_dc, rd, wr;
        logic [15:0] addr, wdata;
        mw_t         mw;
    } exp_t;

    typedef struct packed {
        logic        stall, rd, wr;
        logic [15:0] addr, wdata;
        mw_t         mw;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] inXOut, inRead2Data, inPlusTwoPC;
    logic [2:0]  inWriteRegister;
    logic        inMemoryWrite, inMemoryRead, inMemoryToRegister, inRegisterWrite;
    logic        inHalt, inCreateDump, inLink;
    logic        stall;
    logic [15:0] outReadData, outXout, outPlusTwoPC;
    logic [2:0]  outWriteRegister;
    logic        outRegisterWrite, outMemoryToRegister, outLink, outHalt;
    logic        outCreateDump, outValid, outErr;

    mem_stage_ctrl_if u_if ();

    mem_stage_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(8)) u_dut (
        .clk                (clk),
        .rst                (rst),
        .inXOut             (inXOut),
        .inRead2Data        (inRead2Data),
        .inPlusTwoPC        (inPlusTwoPC),
        .inWriteRegister    (inWriteRegister),
        .inMemoryWrite      (inMemoryWrite),
        .inMemoryRead       (inMemoryRead),
        .inMemoryToRegister (inMemoryToRegister),
        .inRegisterWrite    (inRegisterWrite),
        .inHalt             (inHalt),
        .inCreateDump       (inCreateDump),
        .inLink             (inLink),
        .mem                (u_if),
        .stall              (stall),
        .outReadData        (outReadData),
        .outXout            (outXout),
        .outPlusTwoPC       (outPlusTwoPC),
        .outWriteRegister   (outWriteRegister),
        .outRegisterWrite   (outRegisterWrite),
        .outMemoryToRegister(outMemoryToRegister),
        .outLink            (outLink),
        .outHalt            (outHalt),
        .outCreateDump      (outCreateDump),
        .outValid           (outValid),
        .outErr             (outErr)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    obs_t obs_q[$];
    exp_t ce;
    obs_t co;
    mw_t  cur_mw, nxt_mw;
    int   idle_done_mode = 0;

    task automatic chk(input string n, input logic [15:0] a, input logic [15:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s cycle %0d actual %h expected %h", n, obs_q.size(), a, x);
        end
    endtask

    // Single compare process: every cycle with an expectation is checked.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            ce = exp_q.pop_front();
            co.stall = stall;
            co.rd    = u_if.memRd;
            co.wr    = u_if.memWr;
            co.addr  = u_if.memAddr;
            co.wdata = u_if.memWrData;
            co.mw    = '{rd: outReadData, x: outXout, pc: outPlusTwoPC, wreg: outWriteRegister,
                         rw: outRegisterWrite, m2r: outMemoryToRegister, link: outLink,
                         halt: outHalt, dump: outCreateDump, valid: outValid, err: outErr};
            if (!ce.stall_dc) chk("stall", {15'd0, co.stall}, {15'd0, ce.stall});
            chk("memRd",               {15'd0, co.rd},        {15'd0, ce.rd});
            chk("memWr",               {15'd0, co.wr},        {15'd0, ce.wr});
            chk("memAddr",             co.addr,               ce.addr);
            chk("memWrData",           co.wdata,              ce.wdata);
            chk("outReadData",         co.mw.rd,              ce.mw.rd);
            chk("outXout",             co.mw.x,               ce.mw.x);
            chk("outPlusTwoPC",        co.mw.pc,              ce.mw.pc);
            chk("outWriteRegister",    {13'd0, co.mw.wreg},   {13'd0, ce.mw.wreg});
            chk("outRegisterWrite",    {15'd0, co.mw.rw},     {15'd0, ce.mw.rw});
            chk("outMemoryToRegister", {15'd0, co.mw.m2r},    {15'd0, ce.mw.m2r});
            chk("outLink",             {15'd0, co.mw.link},   {15'd0, ce.mw.link});
            chk("outHalt",             {15'd0, co.mw.halt},   {15'd0, ce.mw.halt});
            chk("outCreateDump",       {15'd0, co.mw.dump},   {15'd0, ce.mw.dump});
            chk("outValid",            {15'd0, co.mw.valid},  {15'd0, ce.mw.valid});
            chk("outErr",              {15'd0, co.mw.err},    {15'd0, ce.mw.err});
            obs_q.push_back(co);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cur_mw = nxt_mw;
    endtask

    task automatic expect_cycle(input logic s, input logic sdc, input logic r, input logic w,
                                input mw_t n);
        exp_t e;
        e.stall    = s;
        e.stall_dc = sdc;
        e.rd       = r;
        e.wr       = w;
        e.addr     = inXOut;
        e.wdata    = inRead2Data;
        e.mw       = cur_mw;
        exp_q.push_back(e);
        nxt_mw = n;
    endtask

    // One EX/MEM instruction; delay = WAIT cycle index of memDone (>= T means never),
    // rst_k = WAIT cycle index at which reset is pulsed (-1 for none).
    task automatic run_instr(input logic [15:0] x, input logic [15:0] wd, input logic [15:0] pc,
                             input logic [2:0] wreg, input logic mrd, input logic mwr,
                             input logic m2r, input logic rw, input logic halt,
                             input logic dump, input logic link, input int delay,
                             input int rst_k, input logic [15:0] rdat, output int idx);
        mw_t pass, fault, res;
        tick();
        idx = obs_q.size();
        rst = 1'b0;
        inXOut = x; inRead2Data = wd; inPlusTwoPC = pc; inWriteRegister = wreg;
        inMemoryRead = mrd; inMemoryWrite = mwr; inMemoryToRegister = m2r;
        inRegisterWrite = rw; inHalt = halt; inCreateDump = dump; inLink = link;
        u_if.memDone   = (idle_done_mode != 0) ? 1'b1 : 1'($urandom_range(0, 1));
        u_if.memRdData = 16'($urandom);
        pass  = '{rd: 16'h0, x: x, pc: pc, wreg: wreg, rw: rw, m2r: m2r, link: link,
                  halt: halt, dump: dump, valid: 1'b1, err: 1'b0};
        fault = pass;
        fault.rw = 1'b0; fault.halt = 1'b1; fault.err = 1'b1;
        if (!(mrd | mwr)) begin
            expect_cycle(1'b0, 1'b0, 1'b0, 1'b0, pass);
        end else if (x[0]) begin
            expect_cycle(1'b0, 1'b0, 1'b0, 1'b0, fault);
        end else begin
            expect_cycle(1'b1, 1'b0, mrd & ~mwr, mwr, '0);
            for (int k = 0; k < T; k++) begin
                tick();
                u_if.memDone   = 1'b0;
                u_if.memRdData = 16'($urandom);
                if (k == rst_k) begin
                    rst = 1'b1;
                    expect_cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
                    return;
                end else if (k == delay) begin
                    u_if.memDone   = 1'b1;
                    u_if.memRdData = rdat;
                    res    = pass;
                    res.rd = mwr ? 16'h0 : rdat;
                    expect_cycle(1'b0, 1'b0, 1'b0, 1'b0, res);
                    return;
                end else if (k == T - 1) begin
                    expect_cycle(1'b0, 1'b0, 1'b0, 1'b0, fault);
                end else begin
                    expect_cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
                end
            end
        end
    endtask

    initial begin
        int i_alu, i_ld, i_st, i_mis, i_to, i_late, i_rst, i_post, i_tmp, ssum;
        logic [15:0] rx;
        int kind, dly, rk;
        logic rmrd, rmwr;

        rst = 1'b1;
        inXOut = 16'h0; inRead2Data = 16'h0; inPlusTwoPC = 16'h0; inWriteRegister = 3'd0;
        inMemoryRead = 1'b0; inMemoryWrite = 1'b0; inMemoryToRegister = 1'b0;
        inRegisterWrite = 1'b0; inHalt = 1'b0; inCreateDump = 1'b0; inLink = 1'b0;
        u_if.memDone = 1'b0; u_if.memRdData = 16'h0;
        nxt_mw = '0;
        repeat (2) @(posedge clk);
        tick();
        expect_cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);

        // Directed scenarios.
        run_instr(16'h1234, 16'h0, 16'h0102, 3'd3, 0, 0, 0, 1, 0, 0, 0, 99, -1, 16'h0, i_alu);
        run_instr(16'h0040, 16'h0, 16'h0104, 3'd1, 1, 0, 1, 1, 0, 0, 0, 1, -1, 16'hBEEF, i_ld);
        run_instr(16'h0010, 16'hA5A5, 16'h0106, 3'd0, 0, 1, 0, 0, 0, 0, 0, 0, -1, 16'h7777, i_st);
        run_instr(16'h0041, 16'h0, 16'h0108, 3'd2, 1, 0, 1, 1, 0, 0, 0, 0, -1, 16'h1111, i_mis);
        run_instr(16'h0080, 16'h0, 16'h010A, 3'd4, 1, 0, 1, 1, 0, 0, 0, 99, -1, 16'h0, i_to);
        run_instr(16'h0082, 16'h0, 16'h010C, 3'd4, 1, 0, 1, 1, 0, 0, 0, T - 1, -1, 16'h5A5A, i_late);
        run_instr(16'h0084, 16'h0, 16'h010E, 3'd6, 1, 0, 1, 1, 0, 0, 0, 99, 3, 16'h0, i_rst);
        idle_done_mode = 1;
        run_instr(16'h0BCD, 16'h0, 16'h0110, 3'd5, 0, 0, 0, 1, 0, 0, 0, 99, -1, 16'h0, i_post);
        idle_done_mode = 0;

        // Randomized instruction stream.
        repeat (300) begin
            kind = $urandom_range(0, 9);
            rx   = 16'($urandom);
            rmrd = (kind >= 3 && kind <= 5) || kind == 8 || kind == 9;
            rmwr = (kind == 6 || kind == 7 || kind == 8);
            if (rmrd | rmwr) rx[0] = (kind == 9);
            dly = ($urandom_range(0, 5) == 0) ? 99 : $urandom_range(0, T - 1);
            rk  = ($urandom_range(0, 19) == 0) ? $urandom_range(0, T - 1) : -1;
            run_instr(rx, 16'($urandom), 16'($urandom), 3'($urandom), rmrd, rmwr,
                      1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      dly, rk, 16'($urandom), i_tmp);
        end
        run_instr(16'h0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 99, -1, 16'h0, i_tmp);
        @(negedge clk);
        #1;

        // Hand-computed literal expectations for the directed scenarios.
        chk("alu_no_stall",   {15'd0, obs_q[i_alu].stall},        16'd0);
        chk("alu_xout",       obs_q[i_alu + 1].mw.x,              16'h1234);
        chk("alu_valid_rw",   {14'd0, obs_q[i_alu + 1].mw.valid, obs_q[i_alu + 1].mw.rw}, 16'd3);
        chk("alu_wreg",       {13'd0, obs_q[i_alu + 1].mw.wreg},  16'd3);
        chk("ld_rd_pulse",    {14'd0, obs_q[i_ld].rd, obs_q[i_ld + 1].rd}, 16'd2);
        ssum = 0;
        for (int c = 0; c < 3; c++) ssum += int'(obs_q[i_ld + c].stall);
        chk("ld_stall_cycles", 16'(ssum), 16'd2);
        chk("ld_bubbles",     {14'd0, obs_q[i_ld + 1].mw.valid, obs_q[i_ld + 2].mw.valid}, 16'd0);
        chk("ld_data",        obs_q[i_ld + 3].mw.rd,              16'hBEEF);
        chk("ld_valid",       {15'd0, obs_q[i_ld + 3].mw.valid},  16'd1);
        chk("st_wr",          {15'd0, obs_q[i_st].wr},            16'd1);
        chk("st_addr",        obs_q[i_st].addr,                   16'h0010);
        chk("st_wdata",       obs_q[i_st].wdata,                  16'hA5A5);
        chk("st_result",      {15'd0, obs_q[i_st + 2].mw.valid} | obs_q[i_st + 2].mw.rd, 16'd1);
        chk("mis_req",        {14'd0, obs_q[i_mis].rd, obs_q[i_mis].stall}, 16'd0);
        chk("mis_flags",      {13'd0, obs_q[i_mis + 1].mw.err, obs_q[i_mis + 1].mw.halt,
                               obs_q[i_mis + 1].mw.rw}, 16'd6);
        ssum = 0;
        for (int c = 0; c < 16; c++) ssum += int'(obs_q[i_to + c].stall);
        chk("to_stall_cycles", 16'(ssum), 16'd15);
        chk("to_flags",       {14'd0, obs_q[i_to + 16].mw.err, obs_q[i_to + 16].mw.halt}, 16'd3);
        chk("to_err_once",    {15'd0, obs_q[i_to + 17].mw.err},   16'd0);
        chk("late_ok",        {14'd0, obs_q[i_late + 16].mw.valid, obs_q[i_late + 16].mw.err}, 16'd2);
        chk("late_data",      obs_q[i_late + 16].mw.rd,           16'h5A5A);
        chk("rst_clear",      16'(obs_q[i_rst + 5].mw != '0),     16'd0);
        chk("post_xout",      obs_q[i_post + 1].mw.x,             16'h0BCD);
        chk("post_valid_rd",  {15'd0, obs_q[i_post + 1].mw.valid} | obs_q[i_post + 1].mw.rd, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
